// File: rtl/matrix_control_unit.sv
// Command sequencer for the 5x5 matrix ALU: loads operands, launches an operation,
// captures the result and returns one status/data response per host instruction.
module matrix_control_unit #(
    parameter int ALU_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instr,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [7:0]   rsp_data,
    output logic [1:0]   rsp_status,
    output logic [199:0] alu_A_flat,
    output logic [199:0] alu_B_flat,
    output logic [7:0]   alu_f,
    output logic [2:0]   alu_opcode,
    input  logic [199:0] alu_C_flat,
    input  logic         alu_overflow
);

    localparam int DATA_W = 8;
    localparam int MAT_W  = 25 * DATA_W;

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_LOAD_A = 3'b001;
    localparam logic [2:0] CMD_LOAD_B = 3'b010;
    localparam logic [2:0] CMD_EXEC   = 3'b011;
    localparam logic [2:0] CMD_READ   = 3'b100;
    localparam logic [2:0] CMD_CLEAR  = 3'b101;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_OVF = 2'b01;
    localparam logic [1:0] ST_ERR = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(ALU_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [MAT_W-1:0]  a_q, a_d;
    logic [MAT_W-1:0]  b_q, b_d;
    logic [MAT_W-1:0]  c_q, c_d;
    logic [DATA_W-1:0] scalar_q, scalar_d;
    logic [2:0]        op_q, op_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_status_q, rsp_status_d;

    logic [2:0]        cmd;
    logic [2:0]        row;
    logic [2:0]        col;
    logic [DATA_W-1:0] data;
    logic [2:0]        aop;
    logic              idx_ok;
    logic [7:0]        base;

    // Bit offset of element (r,c) in a flattened row-major matrix.
    function automatic logic [7:0] elem_base(input logic [2:0] r, input logic [2:0] c);
        logic [7:0] idx;
        idx = 8'(r) * 8'd5 + 8'(c);
        return {idx[4:0], 3'b000};
    endfunction

    assign cmd    = instr[2:0];
    assign row    = instr[5:3];
    assign col    = instr[8:6];
    assign data   = instr[16:9];
    assign aop    = instr[19:17];
    assign idx_ok = (row <= 3'd4) && (col <= 3'd4);
    assign base   = elem_base(row, col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            scalar_q     <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            scalar_q     <= scalar_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        scalar_d     = scalar_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    rsp_data_d   = '0;
                    rsp_status_d = ST_OK;
                    state_d      = S_RESP;
                    case (cmd)
                        CMD_NOP: ;
                        CMD_LOAD_A: begin
                            if (idx_ok) a_d[base +: DATA_W] = data;
                            else        rsp_status_d = ST_ERR;
                        end
                        CMD_LOAD_B: begin
                            if (idx_ok) b_d[base +: DATA_W] = data;
                            else        rsp_status_d = ST_ERR;
                        end
                        CMD_EXEC: begin
                            // Opcode 000 is the ALU idle code, so it cannot be launched.
                            if (aop == 3'b000) begin
                                rsp_status_d = ST_ERR;
                            end else begin
                                scalar_d = data;
                                op_d     = aop;
                                state_d  = S_SETUP;
                            end
                        end
                        CMD_READ: begin
                            if (idx_ok) rsp_data_d   = c_q[base +: DATA_W];
                            else        rsp_status_d = ST_ERR;
                        end
                        CMD_CLEAR: begin
                            a_d = '0;
                            b_d = '0;
                            c_d = '0;
                        end
                        default: rsp_status_d = ST_ERR;
                    endcase
                end
            end
            S_SETUP: begin
                cnt_d   = WAIT_LAST;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    c_d          = alu_C_flat;
                    rsp_data_d   = '0;
                    rsp_status_d = alu_overflow ? ST_OVF : ST_OK;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SETUP drives 000 so the ALU sees an opcode edge even when the same op repeats.
    assign alu_opcode  = (state_q == S_WAIT) ? op_q : 3'b000;
    assign instr_ready = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign alu_A_flat  = a_q;
    assign alu_B_flat  = b_q;
    assign alu_f       = scalar_q;

endmodule

// File: tb/tb_matrix_control_unit.sv
// Scoreboard bench for matrix_control_unit with a wrapping element-wise-add ALU model.
module tb_matrix_control_unit;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] OVF = 2'b01;
    localparam logic [1:0] ERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [31:0]  instr = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [7:0]   rsp_data;
    logic [1:0]   rsp_status;
    logic [199:0] alu_A_flat;
    logic [199:0] alu_B_flat;
    logic [7:0]   alu_f;
    logic [2:0]   alu_opcode;
    logic [199:0] alu_C_flat;
    logic         alu_overflow;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    matrix_control_unit #(.ALU_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .alu_A_flat(alu_A_flat), .alu_B_flat(alu_B_flat), .alu_f(alu_f),
        .alu_opcode(alu_opcode), .alu_C_flat(alu_C_flat), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    // ALU model: opcode 001 is element-wise signed add, wrapping, with overflow flag.
    logic signed [8:0] s;
    always_comb begin
        alu_C_flat   = '0;
        alu_overflow = 1'b0;
        s            = '0;
        if (alu_opcode == 3'b001) begin
            for (int i = 0; i < 25; i++) begin
                s = $signed({alu_A_flat[8*i+7], alu_A_flat[8*i +: 8]})
                  + $signed({alu_B_flat[8*i+7], alu_B_flat[8*i +: 8]});
                alu_C_flat[8*i +: 8] = s[7:0];
                if (s > 9'sd127 || s < -9'sd128) alu_overflow = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] cmd, input logic [2:0] r,
                                       input logic [2:0] c, input logic [7:0] d,
                                       input logic [2:0] op);
        return {12'b0, op, d, c, r, cmd};
    endfunction

    // Monitor: every response handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e[9:2]);
                chk("rsp_status", rsp_status, e[1:0]);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [7:0] ed, input logic [1:0] es,
                        input int lat, input logic [2:0] op);
        int n;
        int k;
        exp_q.push_back({ed, es});
        instr       = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 50) begin
            chk("alu_opcode_seq", alu_opcode, (k >= 2) ? op : 3'b000);
            @(posedge clk); #1;
            k++;
        end
        chk("alu_opcode_at_rsp", alu_opcode, 0);
        chk("rsp_latency", k, lat);
    endtask

    task automatic finish_rsp();
        @(posedge clk); #1;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("instr_ready_back", instr_ready, 1);
    endtask

    task automatic xfer(input logic [31:0] w, input logic [7:0] ed, input logic [1:0] es,
                        input int lat, input logic [2:0] op);
        send(w, ed, es, lat, op);
        finish_rsp();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_alu_f", alu_f, 0);
        chk("rst_alu_A", alu_A_flat, 0);
        chk("rst_alu_B", alu_B_flat, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d0;
        logic [1:0] s0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(mk(3'd4, 3'd2, 3'd3, 8'h00, 3'd0), 8'h00, OK, 1, 3'd0);

        xfer(mk(3'd1, 3'd0, 3'd0, 8'h05, 3'd0), 8'h00, OK, 1, 3'd0);
        xfer(mk(3'd2, 3'd0, 3'd0, 8'h03, 3'd0), 8'h00, OK, 1, 3'd0);
        xfer(mk(3'd3, 3'd0, 3'd0, 8'h33, 3'd1), 8'h00, OK, 6, 3'd1);
        chk("alu_f_scalar", alu_f, 8'h33);
        xfer(mk(3'd4, 3'd0, 3'd0, 8'h00, 3'd0), 8'h08, OK, 1, 3'd0);

        xfer(mk(3'd1, 3'd0, 3'd0, 8'h7F, 3'd0), 8'h00, OK, 1, 3'd0);
        xfer(mk(3'd2, 3'd0, 3'd0, 8'h01, 3'd0), 8'h00, OK, 1, 3'd0);
        xfer(mk(3'd3, 3'd0, 3'd0, 8'h00, 3'd1), 8'h00, OVF, 6, 3'd1);

        xfer(mk(3'd1, 3'd5, 3'd0, 8'hAA, 3'd0), 8'h00, ERR, 1, 3'd0);
        chk("A_unchanged_after_idx_err", alu_A_flat, 200'h7F);
        xfer(mk(3'd3, 3'd0, 3'd0, 8'h00, 3'd0), 8'h00, ERR, 1, 3'd0);
        xfer(mk(3'd4, 3'd0, 3'd7, 8'h00, 3'd0), 8'h00, ERR, 1, 3'd0);
        xfer(mk(3'd6, 3'd0, 3'd0, 8'h00, 3'd0), 8'h00, ERR, 1, 3'd0);
        xfer(mk(3'd0, 3'd0, 3'd0, 8'h00, 3'd0), 8'h00, OK, 1, 3'd0);

        xfer(mk(3'd1, 3'd1, 3'd2, 8'h10, 3'd0), 8'h00, OK, 1, 3'd0);
        chk("A_elem_1_2", alu_A_flat[63:56], 8'h10);

        // Response back-pressure with a second instruction waiting.
        rsp_ready = 1'b0;
        send(mk(3'd3, 3'd0, 3'd0, 8'h00, 3'd1), 8'h00, OVF, 6, 3'd1);
        d0 = rsp_data;
        s0 = rsp_status;
        chk("stall_status", s0, OVF);
        exp_q.push_back({8'h10, OK});
        instr       = mk(3'd4, 3'd1, 3'd2, 8'h00, 3'd0);
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_data", rsp_data, d0);
            chk("stall_rsp_status", rsp_status, s0);
            chk("stall_instr_ready", instr_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_instr_ready", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("queued_instr_rsp_valid", rsp_valid, 1);
        finish_rsp();

        xfer(mk(3'd5, 3'd0, 3'd0, 8'h00, 3'd0), 8'h00, OK, 1, 3'd0);
        chk("clear_A", alu_A_flat, 0);
        xfer(mk(3'd4, 3'd1, 3'd2, 8'h00, 3'd0), 8'h00, OK, 1, 3'd0);

        // Reset in the middle of an EXEC.
        xfer(mk(3'd1, 3'd0, 3'd0, 8'h44, 3'd0), 8'h00, OK, 1, 3'd0);
        xfer(mk(3'd2, 3'd0, 3'd0, 8'h01, 3'd0), 8'h00, OK, 1, 3'd0);
        instr       = mk(3'd3, 3'd0, 3'd0, 8'h22, 3'd1);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_wait_opcode", alu_opcode, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(mk(3'd4, 3'd0, 3'd0, 8'h00, 3'd0), 8'h00, OK, 1, 3'd0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_control_unit.md
# matrix_control_unit

Command sequencer that drives the matrix ALU, acting as the initiator on its operand/opcode interface. The block:
- accepts 32-bit instructions from the host over a valid/ready channel;
- loads 5x5 signed 8-bit operand matrices A and B element by element;
- launches an ALU operation and captures the 200-bit result and overflow flag;
- returns exactly one response per instruction over a valid/ready response channel.

It sits between the host bridge and the ALU.

## Interface
- ALU_WAIT, default 4: cycles the ALU opcode is held before result capture; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  host instruction valid.
- instr_ready  out  1  block can accept an instruction.
- instr  in  32  instruction word:
  - [2:0] cmd; [5:3] row; [8:6] col; [16:9] data/scalar; [19:17] alu op; rest ignored.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  8  response byte.
- rsp_status  out  2  response status: 00 OK, 01 OVF, 10 ERR.
- alu_A_flat  out  200  operand A to ALU.
- alu_B_flat  out  200  operand B to ALU.
- alu_f  out  8  scalar to ALU.
- alu_opcode  out  3  ALU opcode.
- alu_C_flat  in  200  ALU result.
- alu_overflow  in  1  ALU overflow flag.

## Operation
- Element (r,c) maps to bits [8*(5r+c)+7 : 8*(5r+c)] of every 200-bit matrix.
- Registers: A, B, C (200 bits each), scalar (8 bits), op (3 bits).
- cmd 000 NOP: no register change; response OK, data 0.
- cmd 001 LOAD_A: A(r,c) <= instr[16:9]; response OK, data 0.
- cmd 010 LOAD_B: same as LOAD_A, into B.
- cmd 011 EXEC:
  - scalar <= instr[16:9], op <= instr[19:17], then run the ALU sequence.
  - Response data = 0; status = OVF if the captured overflow is 1, else OK.
  - op 000 returns ERR immediately and runs no sequence.
- cmd 100 READ: response data = C(r,c), status OK.
- cmd 101 CLEAR: A, B and C zeroed; response OK.
- cmd 110 and 111: ERR, no state change.
- Index error:
  - Applies to LOAD_A, LOAD_B and READ when row > 4 or col > 4.
  - Response is ERR with data 0; no register is written.
- States: IDLE, SETUP, WAIT, RESP.
  - IDLE: instr_ready = 1.
    - On an accepted EXEC with valid op, go to SETUP.
    - On any other accepted instruction, perform the action and go to RESP.
  - SETUP (1 cycle): alu_opcode = 000, so the ALU sees an opcode change on every EXEC, including a repeat of the same op.
  - WAIT (ALU_WAIT cycles): alu_opcode = op.
    - On the final WAIT edge: C <= alu_C_flat, and the overflow bit is latched.
    - Then go to RESP.
  - RESP: hold rsp_valid until rsp_ready; on handshake go to IDLE.
- alu_A_flat and alu_B_flat are continuous copies of A and B.
- alu_f = scalar.
- alu_opcode = 000 in every state except WAIT.
- instr_ready = 0 in SETUP, WAIT and RESP; instructions arriving then are not consumed.

## Timing
- Reset values:
  - state IDLE, instr_ready 1.
  - rsp_valid 0, rsp_data 0, rsp_status 00.
  - alu_opcode 000, alu_f 0.
  - A, B, C and scalar all 0.
- Accept occurs on a rising edge with instr_valid & instr_ready; call that edge N.
- Latency of non-EXEC instructions and EXEC op 000: rsp_valid high in the cycle after edge N.
- Latency of EXEC: SETUP in cycle N+1, WAIT in cycles N+2..N+1+ALU_WAIT, rsp_valid high from cycle N+2+ALU_WAIT.
- rsp_data and rsp_status are stable while rsp_valid is high and rsp_ready is low.
- Response handshake at edge M: rsp_valid low and instr_ready high from cycle M+1. No same-edge response-to-accept overlap.
- Reset asserted mid-operation: immediate return to reset values; any pending response is discarded; C is zeroed.
- C changes only at EXEC capture and on CLEAR.
- A READ before any EXEC returns 0.
- Back-to-back instructions: maximum throughput is one non-EXEC instruction per 2 cycles when rsp_ready is held high.

## Test plan
- Reset, then READ (2,3) -> data 00, status OK, rsp_valid one cycle after accept.
- Sum with ALU_WAIT = 4:
  - Stimulus: LOAD_A (0,0)=0x05, LOAD_B (0,0)=0x03, EXEC op 001.
  - Required: alu_opcode 000 for 1 cycle, then 001 for 4 cycles; rsp_valid 6 cycles after accept; status OK.
  - READ (0,0) -> 0x08.
- LOAD_A (0,0)=0x7F, LOAD_B (0,0)=0x01, EXEC op 001 -> status OVF.
- LOAD_A row 5, col 0 -> status ERR, A unchanged. EXEC op 000 -> ERR in 1 cycle; alu_opcode stays 000.
- Hold rsp_ready low 10 cycles after an EXEC -> rsp_valid and status stable, instr_ready 0, and a second instruction presented meanwhile is not consumed until after the response handshake.
- Assert rst during WAIT -> next cycle all outputs at reset values; READ (0,0) -> 0x00.
